// File: rtl/led_anim_pkg.sv
// rtl/led_anim_pkg.sv - shared encodings and defaults for the LED bar frame monitor
package led_anim_pkg;

    localparam int LED_WIDTH = 16;
    localparam int CLK_HZ    = 100_000_000;

    // Sweep state encodings
    localparam logic [1:0] ST_IDLE = 2'b00;
    localparam logic [1:0] ST_HOLD = 2'b01;
    localparam logic [1:0] ST_UP   = 2'b10;
    localparam logic [1:0] ST_DOWN = 2'b11;

    // Direction output encodings
    localparam logic [1:0] DIR_HOLD = 2'b00;
    localparam logic [1:0] DIR_UP   = 2'b01;
    localparam logic [1:0] DIR_DN   = 2'b10;

endpackage

// File: rtl/thermo_decode.sv
// rtl/thermo_decode.sv - MSB-first thermometer code decoder (combinational)
module thermo_decode #(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0]               frame,
    output logic                           legal,
    output logic [$clog2(WIDTH+1)-1:0]     level
);

    localparam int LW = $clog2(WIDTH+1);

    // Match the frame against every legal bar length; at most one can hit
    always_comb begin
        legal = 1'b0;
        level = '0;
        for (int l = 0; l <= WIDTH; l++) begin
            if (frame == ~({WIDTH{1'b1}} >> l)) begin
                legal = 1'b1;
                level = LW'(l);
            end
        end
    end

endmodule

// File: rtl/led_frame_monitor.sv
// rtl/led_frame_monitor.sv - LED bar frame checker: level, direction, errors, frame period
module led_frame_monitor
    import led_anim_pkg::*;
#(
    parameter int WIDTH    = LED_WIDTH,
    parameter int PERIOD_W = 27,
    parameter int ERRCNT_W = 8
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [WIDTH-1:0]               frame,
    input  logic                           frame_stb,
    output logic [$clog2(WIDTH+1)-1:0]     level,
    output logic [1:0]                     dir,
    output logic                           code_err,
    output logic                           step_err,
    output logic [ERRCNT_W-1:0]            err_cnt,
    output logic [PERIOD_W-1:0]            period,
    output logic                           period_vld
);

    localparam int LW = $clog2(WIDTH+1);
    localparam logic [LW-1:0] LVL_MAX = LW'(WIDTH);

    logic              dec_legal;
    logic [LW-1:0]     dec_level;
    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic              step_bad;
    logic [LW:0]       new_ext;
    logic [LW:0]       old_ext;
    logic [PERIOD_W-1:0] gap_cnt;
    logic              seen_stb;

    thermo_decode #(.WIDTH(WIDTH)) u_decode (
        .frame (frame),
        .legal (dec_legal),
        .level (dec_level)
    );

    assign new_ext = {1'b0, dec_level};
    assign old_ext = {1'b0, level};

    // Next sweep state and step legality for a legal incoming level
    always_comb begin
        state_nxt = state;
        step_bad  = 1'b0;
        if (state == ST_IDLE) begin
            state_nxt = ST_HOLD;
        end else if (new_ext == old_ext) begin
            state_nxt = ST_HOLD;
        end else if (new_ext == old_ext + 1'b1) begin
            state_nxt = ST_UP;
            // Turning back up is only clean from the empty bar
            step_bad  = (state == ST_DOWN) && (level != '0);
        end else if (new_ext + 1'b1 == old_ext) begin
            state_nxt = ST_DOWN;
            // Turning back down is only clean from the full bar
            step_bad  = (state == ST_UP) && (level != LVL_MAX);
        end else begin
            state_nxt = ST_HOLD;
            step_bad  = 1'b1;
        end
    end

    // Frame-strobe handling: level, state, error pulses and saturating error count
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            level    <= '0;
            code_err <= 1'b0;
            step_err <= 1'b0;
            err_cnt  <= '0;
        end else begin
            code_err <= 1'b0;
            step_err <= 1'b0;
            if (frame_stb) begin
                if (!dec_legal) begin
                    code_err <= 1'b1;
                    if (err_cnt != '1) err_cnt <= err_cnt + 1'b1;
                end else begin
                    level    <= dec_level;
                    state    <= state_nxt;
                    step_err <= step_bad;
                    if (step_bad && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
                end
            end
        end
    end

    // Strobe-to-strobe gap measurement; the first strobe only arms the counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gap_cnt    <= '0;
            seen_stb   <= 1'b0;
            period     <= '0;
            period_vld <= 1'b0;
        end else if (frame_stb) begin
            gap_cnt  <= PERIOD_W'(1);
            seen_stb <= 1'b1;
            if (seen_stb) begin
                period     <= gap_cnt;
                period_vld <= 1'b1;
            end
        end else if (gap_cnt != '1) begin
            gap_cnt <= gap_cnt + 1'b1;
        end
    end

    // Direction is a pure decode of the registered sweep state
    always_comb begin
        case (state)
            ST_UP:   dir = DIR_UP;
            ST_DOWN: dir = DIR_DN;
            default: dir = DIR_HOLD;
        endcase
    end

endmodule

// File: tb/tb_led_frame_monitor.sv
// tb/tb_led_frame_monitor.sv - randomized self-checking bench for led_frame_monitor
module tb_led_frame_monitor;

    localparam int W   = 16;
    localparam int PW  = 27;
    localparam int EW  = 8;
    localparam int PMAX = (1 << PW) - 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  frame = '0;
    logic          frame_stb = 1'b0;
    logic [4:0]    level;
    logic [1:0]    dir;
    logic          code_err;
    logic          step_err;
    logic [EW-1:0] err_cnt;
    logic [PW-1:0] period;
    logic          period_vld;

    int passed = 0;
    int total  = 0;
    int cyc    = 0;

    // reference model state
    bit m_valid, m_has, m_code, m_step, m_vld;
    int m_level, m_dir, m_err, m_period, m_last;

    led_frame_monitor dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .frame      (frame),
        .frame_stb  (frame_stb),
        .level      (level),
        .dir        (dir),
        .code_err   (code_err),
        .step_err   (step_err),
        .err_cnt    (err_cnt),
        .period     (period),
        .period_vld (period_vld)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    function automatic logic [W-1:0] thermo(input int l);
        logic [W-1:0] ones;
        ones = '1;
        return ~(ones >> l);
    endfunction

    function automatic bit is_legal(input logic [W-1:0] f);
        return f == thermo($countones(f));
    endfunction

    function automatic logic [W-1:0] rand_illegal();
        logic [W-1:0] f;
        f = W'($urandom);
        while (is_legal(f)) f = W'($urandom);
        return f;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_has = 0; m_code = 0; m_step = 0; m_vld = 0;
        m_level = 0; m_dir = 0; m_err = 0; m_period = 0; m_last = 0;
    endtask

    // bar-level rules: +/-1 steps move, reversal only at the ends, bigger jumps are errors
    task automatic model_frame(input logic [W-1:0] f);
        int l, d;
        m_code = 0;
        m_step = 0;
        if (!is_legal(f)) begin
            m_code = 1;
        end else begin
            l = $countones(f);
            if (!m_valid) begin
                m_valid = 1;
                m_dir = 0;
            end else begin
                d = l - m_level;
                if (d == 0) m_dir = 0;
                else if (d == 1) begin
                    if (m_dir == 2 && m_level != 0) m_step = 1;
                    m_dir = 1;
                end else if (d == -1) begin
                    if (m_dir == 1 && m_level != W) m_step = 1;
                    m_dir = 2;
                end else begin
                    m_step = 1;
                    m_dir = 0;
                end
            end
            m_level = l;
        end
        if ((m_code || m_step) && m_err < 255) m_err++;
        if (m_has) begin
            m_period = (cyc - m_last > PMAX) ? PMAX : cyc - m_last;
            m_vld = 1;
        end
        m_has = 1;
        m_last = cyc;
    endtask

    task automatic send(input logic [W-1:0] f);
        frame = f;
        frame_stb = 1'b1;
        @(negedge clk);
        frame_stb = 1'b0;
        frame = W'($urandom);
        model_frame(f);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        frame_stb = 1'b0;
        idle(2);
        rst_n = 1'b1;
        model_reset();
        idle(1);
    endtask

    task automatic test_reset();
        do_reset();
        total++; if ({level, dir, code_err, step_err} !== 9'd0) $display("FAIL reset_lvl_dir got %0d/%0d exp 0/0", level, dir); else passed++;
        total++; if (err_cnt !== 8'd0) $display("FAIL reset_errcnt got %0d exp 0", err_cnt); else passed++;
        total++; if ({period, period_vld} !== 28'd0) $display("FAIL reset_period got %0d/%0d exp 0/0", period, period_vld); else passed++;
    endtask

    task automatic test_sweep();
        int seq[$];
        int ed;
        do_reset();
        for (int i = 0; i <= 16; i++) seq.push_back(i);
        for (int i = 15; i >= 0; i--) seq.push_back(i);
        seq.push_back(1);
        foreach (seq[k]) begin
            send(thermo(seq[k]));
            ed = (k == 0) ? 0 : (seq[k] > seq[k-1]) ? 1 : 2;
            total++; if (level !== 5'(seq[k])) $display("FAIL sweep_level got %0d exp %0d", level, seq[k]); else passed++;
            total++; if (dir !== 2'(ed)) $display("FAIL sweep_dir got %0d exp %0d", dir, ed); else passed++;
            total++; if (code_err !== 1'b0 || step_err !== 1'b0) $display("FAIL sweep_err got %0d%0d exp 00", code_err, step_err); else passed++;
            total++; if (period_vld !== (k != 0)) $display("FAIL sweep_vld got %0d exp %0d", period_vld, k != 0); else passed++;
            idle(9);
        end
        total++; if (period !== 27'd10) $display("FAIL sweep_period got %0d exp 10", period); else passed++;
        total++; if (err_cnt !== 8'd0) $display("FAIL sweep_errcnt got %0d exp 0", err_cnt); else passed++;
    endtask

    task automatic test_code_err();
        do_reset();
        send(thermo(3)); idle(2);
        send(thermo(4)); idle(2);
        send(16'hA000);
        total++; if (code_err !== 1'b1) $display("FAIL code_pulse got %0d exp 1", code_err); else passed++;
        total++; if (err_cnt !== 8'd1) $display("FAIL code_errcnt got %0d exp 1", err_cnt); else passed++;
        total++; if (level !== 5'd4 || dir !== 2'b01) $display("FAIL code_keep got %0d/%0d exp 4/1", level, dir); else passed++;
        total++; if (step_err !== 1'b0) $display("FAIL code_nostep got %0d exp 0", step_err); else passed++;
        idle(1);
        total++; if (code_err !== 1'b0) $display("FAIL code_pulse_end got %0d exp 0", code_err); else passed++;
    endtask

    task automatic test_jump();
        do_reset();
        send(thermo(3)); idle(3);
        send(thermo(5));
        total++; if (step_err !== 1'b1) $display("FAIL jump_pulse got %0d exp 1", step_err); else passed++;
        total++; if (level !== 5'd5 || dir !== 2'b00) $display("FAIL jump_state got %0d/%0d exp 5/0", level, dir); else passed++;
        total++; if (err_cnt !== 8'd1) $display("FAIL jump_errcnt got %0d exp 1", err_cnt); else passed++;
    endtask

    task automatic test_reversal();
        do_reset();
        send(thermo(7)); send(thermo(8)); send(thermo(9));
        total++; if (step_err !== 1'b0 || dir !== 2'b01) $display("FAIL rev_up got %0d/%0d exp 0/1", step_err, dir); else passed++;
        send(thermo(8));
        total++; if (step_err !== 1'b1) $display("FAIL rev_pulse got %0d exp 1", step_err); else passed++;
        total++; if (level !== 5'd8 || dir !== 2'b10) $display("FAIL rev_state got %0d/%0d exp 8/2", level, dir); else passed++;
        total++; if (period !== 27'd1 || period_vld !== 1'b1) $display("FAIL rev_period got %0d/%0d exp 1/1", period, period_vld); else passed++;
    endtask

    task automatic test_saturation();
        do_reset();
        send(thermo(6));
        for (int i = 0; i < 260; i++) send(rand_illegal());
        total++; if (err_cnt !== 8'd255) $display("FAIL sat_errcnt got %0d exp 255", err_cnt); else passed++;
        total++; if (code_err !== 1'b1 || level !== 5'd6) $display("FAIL sat_state got %0d/%0d exp 1/6", code_err, level); else passed++;
        send(thermo(7));
        total++; if (err_cnt !== 8'd255 || code_err !== 1'b0) $display("FAIL sat_legal got %0d/%0d exp 255/0", err_cnt, code_err); else passed++;
        total++; if (level !== 5'd7 || dir !== 2'b01) $display("FAIL sat_level got %0d/%0d exp 7/1", level, dir); else passed++;
    endtask

    task automatic test_reset_mid_sweep();
        do_reset();
        for (int i = 0; i <= 11; i++) begin send(thermo(i)); idle(2); end
        total++; if (level !== 5'd11 || dir !== 2'b01) $display("FAIL mid_pre got %0d/%0d exp 11/1", level, dir); else passed++;
        #2 rst_n = 1'b0;
        #1;
        total++; if ({level, dir, code_err, step_err, err_cnt} !== 17'd0) $display("FAIL mid_async got %0d/%0d exp 0/0", level, dir); else passed++;
        total++; if ({period, period_vld} !== 28'd0) $display("FAIL mid_period got %0d/%0d exp 0/0", period, period_vld); else passed++;
        idle(2);
        rst_n = 1'b1;
        model_reset();
        idle(2);
        send(thermo(2));
        total++; if (level !== 5'd2 || dir !== 2'b00) $display("FAIL mid_first got %0d/%0d exp 2/0", level, dir); else passed++;
        total++; if (step_err !== 1'b0 || period_vld !== 1'b0) $display("FAIL mid_flags got %0d/%0d exp 0/0", step_err, period_vld); else passed++;
    endtask

    task automatic test_random();
        int r, l;
        logic [W-1:0] f;
        do_reset();
        for (int n = 0; n < 400; n++) begin
            r = $urandom_range(0, 9);
            l = m_level;
            if (r < 2)      f = rand_illegal();
            else if (r < 5) f = thermo(l < W ? l + 1 : l - 1);
            else if (r < 8) f = thermo(l > 0 ? l - 1 : l + 1);
            else if (r == 8) f = thermo(l);
            else            f = thermo($urandom_range(0, W));
            send(f);
            total++; if (level !== 5'(m_level) || dir !== 2'(m_dir)) $display("FAIL rnd_state got %0d/%0d exp %0d/%0d", level, dir, m_level, m_dir); else passed++;
            total++; if (code_err !== m_code || step_err !== m_step) $display("FAIL rnd_pulse got %0d%0d exp %0d%0d", code_err, step_err, m_code, m_step); else passed++;
            total++; if (err_cnt !== 8'(m_err)) $display("FAIL rnd_errcnt got %0d exp %0d", err_cnt, m_err); else passed++;
            total++; if (period !== PW'(m_period) || period_vld !== m_vld) $display("FAIL rnd_period got %0d/%0d exp %0d/%0d", period, period_vld, m_period, m_vld); else passed++;
            idle($urandom_range(0, 4));
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_sweep();
        test_code_err();
        test_jump();
        test_reversal();
        test_saturation();
        test_reset_mid_sweep();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
